// File: rtl/mem_stage.sv
// Memory stage: 256x8 data memory, stack pointer, output-port register and the M/WB
// pipeline register. All side effects commit on the edge where the instruction enters WB.
module mem_stage #(
  parameter logic [7:0] SP_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  logic       flush,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  input  logic [7:0] R_ra,
  input  logic [7:0] R_rb,
  input  logic       RW,
  input  logic [1:0] SP,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       out_ld,
  input  logic       MW,
  input  logic       SM1,
  input  logic       SM2,
  input  logic [7:0] res,
  input  logic [7:0] pc_next,
  output logic [1:0] wb_rd,
  output logic       wb_RW,
  output logic       wb_SW1,
  output logic       wb_SW2,
  output logic [7:0] wb_res,
  output logic [7:0] wb_mem,
  output logic [7:0] out_port,
  output logic [7:0] sp
);

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [1:0] SP_PUSH = 2'b01;
  localparam logic [1:0] SP_POP  = 2'b10;

  logic [DW-1:0] mem [DEPTH];

  logic          commit;
  logic [AW-1:0] stack_addr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] sp_next;

  // Register-index B and operand A are not needed in this stage.
  logic unused_ok;
  assign unused_ok = ^{rb, R_ra};

  // Address, write data and next stack pointer for the instruction in M.
  always_comb begin
    commit     = ld & ~flush & ~reset;
    stack_addr = sp;
    sp_next    = sp;
    case (SP)
      SP_PUSH: sp_next = sp - AW'(1);
      SP_POP: begin
        stack_addr = sp + AW'(1);
        sp_next    = sp + AW'(1);
      end
      default: ;
    endcase
    addr  = SM1 ? stack_addr : res;
    wdata = SM2 ? pc_next : R_rb;
  end

  // Data memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && MW) mem[addr] <= wdata;
  end

  // M/WB register, stack pointer and output port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_rd    <= 2'b00;
      wb_RW    <= 1'b0;
      wb_SW1   <= 1'b0;
      wb_SW2   <= 1'b0;
      wb_res   <= '0;
      wb_mem   <= '0;
      out_port <= '0;
      sp       <= SP_RESET;
    end else begin
      if (flush) begin
        wb_rd  <= 2'b00;
        wb_RW  <= 1'b0;
        wb_SW1 <= 1'b0;
        wb_SW2 <= 1'b0;
        wb_res <= '0;
        wb_mem <= '0;
      end else if (ld) begin
        wb_rd  <= ra;
        wb_RW  <= RW;
        wb_SW1 <= SW1;
        wb_SW2 <= SW2;
        wb_res <= res;
        wb_mem <= mem[addr];
      end
      if (commit) sp <= sp_next;
      if (commit && out_ld) out_port <= R_rb;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: an abstract memory/stack model checked every cycle,
// plus hand-computed expectations at key points of the sequence.
module tb_mem_stage;

  logic       clk = 1'b0;
  logic       reset, ld, flush, RW, SW1, SW2, out_ld, MW, SM1, SM2;
  logic [1:0] ra, rb, SP;
  logic [7:0] R_ra, R_rb, res, pc_next;
  logic [1:0] wb_rd;
  logic       wb_RW, wb_SW1, wb_SW2;
  logic [7:0] wb_res, wb_mem, out_port, sp;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage #(.SP_RESET(8'hFF)) dut (
    .clk(clk), .reset(reset), .ld(ld), .flush(flush),
    .ra(ra), .rb(rb), .R_ra(R_ra), .R_rb(R_rb), .RW(RW), .SP(SP),
    .SW1(SW1), .SW2(SW2), .out_ld(out_ld), .MW(MW), .SM1(SM1), .SM2(SM2),
    .res(res), .pc_next(pc_next),
    .wb_rd(wb_rd), .wb_RW(wb_RW), .wb_SW1(wb_SW1), .wb_SW2(wb_SW2),
    .wb_res(wb_res), .wb_mem(wb_mem), .out_port(out_port), .sp(sp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Abstract model: memory array with written flags, a stack pointer and the WB slot.
  logic [7:0] m_mem [256];
  bit         m_val [256];
  logic [7:0] e_sp, e_out, e_res, e_mem, a;
  logic [1:0] e_rd;
  logic       e_RW, e_SW1, e_SW2;
  bit         e_mem_v;
  bit         ready = 0;

  always @(posedge clk) begin
    if (reset) begin
      {e_rd, e_RW, e_SW1, e_SW2, e_res, e_mem} = '0;
      e_mem_v = 1;
      e_sp    = 8'hFF;
      e_out   = 8'h00;
      ready   = 1;
    end else if (ready && flush) begin
      {e_rd, e_RW, e_SW1, e_SW2, e_res, e_mem} = '0;
      e_mem_v = 1;
    end else if (ready && ld) begin
      a = SM1 ? ((SP == 2'b10) ? 8'(e_sp + 8'd1) : e_sp) : res;
      e_mem   = m_mem[a];
      e_mem_v = m_val[a];
      e_rd = ra; e_RW = RW; e_SW1 = SW1; e_SW2 = SW2; e_res = res;
      if (MW) begin
        m_mem[a] = SM2 ? pc_next : R_rb;
        m_val[a] = 1;
      end
      if (SP == 2'b01) e_sp = 8'(e_sp - 8'd1);
      else if (SP == 2'b10) e_sp = 8'(e_sp + 8'd1);
      if (out_ld) e_out = R_rb;
    end
  end

  // Every-cycle comparison against the model; wb_mem only when its source was written.
  always @(negedge clk) begin
    if (ready) begin
      chk("wb_rd",    {6'd0, wb_rd},  {6'd0, e_rd});
      chk("wb_ctl",   {5'd0, wb_RW, wb_SW1, wb_SW2}, {5'd0, e_RW, e_SW1, e_SW2});
      chk("wb_res",   wb_res,   e_res);
      chk("out_port", out_port, e_out);
      chk("sp",       sp,       e_sp);
      if (e_mem_v) chk("wb_mem", wb_mem, e_mem);
    end
  end

  task automatic idle();
    flush = 0; ra = 2'd0; rb = 2'd0; R_ra = 8'h00; R_rb = 8'h00; RW = 0; SP = 2'b00;
    SW1 = 0; SW2 = 0; out_ld = 0; MW = 0; SM1 = 0; SM2 = 0; res = 8'h00; pc_next = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic w);
    idle(); SP = 2'b01; SM1 = 1; MW = w; R_rb = d;
  endtask

  task automatic pop();
    idle(); SP = 2'b10; SM1 = 1; RW = 1; SW2 = 1; ra = 2'd2;
  endtask

  initial begin
    idle(); reset = 1; ld = 0;
    tick(); tick();
    chk("rst_sp", sp, 8'hFF);
    chk("rst_out", out_port, 8'h00);
    chk("rst_wb", {wb_res | wb_mem}, 8'h00);
    reset = 0; ld = 1;

    // Store, load, then read-before-write on the same address.
    idle(); MW = 1; res = 8'h10; R_rb = 8'hA5; ra = 2'd1; RW = 1; SW1 = 1; tick();
    chk("st_wb_res", wb_res, 8'h10);
    idle(); res = 8'h10; tick();
    chk("ld_a5", wb_mem, 8'hA5);
    idle(); MW = 1; res = 8'h10; R_rb = 8'h3C; tick();
    chk("rbw_old", wb_mem, 8'hA5);
    idle(); res = 8'h10; tick();
    chk("ld_3c", wb_mem, 8'h3C);

    // Push/pop and wrap around 0x00 / 0xFF.
    push(8'h11, 1); tick();
    chk("push_sp", sp, 8'hFE);
    pop(); tick();
    chk("pop_mem", wb_mem, 8'h11);
    chk("pop_sp", sp, 8'hFF);
    for (int i = 0; i < 254; i++) begin
      push(8'h00, 0); tick();
    end
    chk("sp_01", sp, 8'h01);
    push(8'h77, 1); tick();
    chk("sp_00", sp, 8'h00);
    push(8'h88, 1); tick();
    chk("wrap_ff", sp, 8'hFF);
    pop(); tick();
    chk("pop_wrap_mem", wb_mem, 8'h88);
    chk("pop_wrap_sp", sp, 8'h00);

    // CALL push of the return address.
    idle(); SP = 2'b01; SM1 = 1; SM2 = 1; MW = 1; pc_next = 8'h42; R_rb = 8'hEE; tick();
    chk("call_sp", sp, 8'hFF);
    pop(); tick();
    chk("call_ret", wb_mem, 8'h42);
    chk("call_pop_sp", sp, 8'h00);

    // Stall for three cycles, then exactly one commit.
    idle(); res = 8'h33; RW = 1; tick();
    ld = 0; push(8'h99, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_sp", sp, 8'h00);
      chk("stall_hold", wb_res, 8'h33);
    end
    ld = 1; tick();
    chk("unstall_sp", sp, 8'hFF);
    pop(); tick();
    chk("unstall_mem", wb_mem, 8'h99);

    // Flushed push: no write, no SP change, bubble in WB.
    flush = 1; push(8'h55, 1); flush = 1; tick();
    chk("flush_sp", sp, 8'h00);
    chk("flush_wb", {7'd0, wb_RW}, 8'h00);
    idle(); res = 8'h00; tick();
    chk("flush_nowr", wb_mem, 8'h99);

    // Output port: commit, flushed attempt, reset.
    idle(); out_ld = 1; R_rb = 8'h5C; tick();
    chk("out_5c", out_port, 8'h5C);
    idle(); flush = 1; out_ld = 1; R_rb = 8'hE7; tick();
    chk("out_flush", out_port, 8'h5C);
    idle(); reset = 1; MW = 1; res = 8'h10; R_rb = 8'hEE; out_ld = 1; tick();
    chk("out_rst", out_port, 8'h00);
    chk("rst_sp2", sp, 8'hFF);
    reset = 0; idle(); res = 8'h10; tick();
    chk("rst_nowr", wb_mem, 8'h3C);

    // Reset during a stall drops the pending write.
    ld = 0; idle(); MW = 1; res = 8'h10; R_rb = 8'hD1; reset = 1; tick();
    reset = 0; ld = 1; idle(); res = 8'h10; tick();
    chk("rst_stall", wb_mem, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
